mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline. It owns the HI and LO registers.
- Executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo with fixed multi-cycle latency.
- Drives `start` and `busy` to the hazard/forward unit, which freezes any md-class instruction in D while either is high.
- Operands arrive already forwarded (ALU A/B forwarding muxes, post-select).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- md_op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd (optional feature only); 10-15 treated as none.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- start  output  1  combinational; high when md_op is 1-4 (or 9 with the optional feature) and the unit is not busy.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_out  output  32  combinational: hi when md_op=5, lo when md_op=6, otherwise 0.

Behaviour:
- Reset (reset=0 at a rising edge): hi=0, lo=0, busy=0, internal counter=0, latched result=0.
  - Takes priority over everything, including an operation in flight; that operation is discarded.
- Launch:
  - In a cycle T with start=1, operands and op are captured at the edge ending T.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from T+1 through T+N.
- Completion:
  - At the edge ending cycle T+N, busy falls and {hi,lo} load the latched result.
  - Both are visible at T+N+1.
  - hi/lo never change during busy cycles.
- Results:
  - mult: {hi,lo} = 64-bit signed product.
  - multu: {hi,lo} = 64-bit unsigned product.
  - div: lo = signed quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Overflow case 0x80000000 / -1 (div): lo=0x80000000, hi=0.
- Divide by zero (rt_val=0 on div/divu): full busy latency still applies; hi and lo remain unchanged at completion.
- mthi/mtlo:
  - Write rs_val to hi/lo at the edge ending the cycle they are presented in.
  - Ignored while busy; the hazard unit guarantees this never occurs.
- mfhi/mflo: md_out reflects hi/lo combinationally in the same cycle. No internal bypass of a same-cycle mthi/mtlo.
- Launch while busy: md_op 1-4 with busy=1 → start=0 and the request is dropped. The in-flight operation is unaffected. This is not reachable in a correct pipeline and must be checked by assertion.
- Back-to-back: a new launch is accepted in cycle T+N+1. There are no idle bubbles beyond that.
- Counter: 4-bit down-counter. busy = (counter != 0). Decrements each cycle while non-zero.
- start is never registered; the hazard unit sees start combined with busy, giving a continuous stall window from T through T+N.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op=9 (madd) launches with MULT_CYCLES latency.
  - At completion, {hi,lo} = {hi,lo} + signed(rs_val*rt_val), mod 2^64.
  - The accumulator sampled is hi/lo as of completion.
- Undefined: md_op=9 is treated as none, start=0, and no state changes.

Test Plan:
- Reset: reset=0 for 2 cycles mid-div (counter at 4) → busy=0, hi=0, lo=0 on the next cycle; md_out=0 with md_op=5.
- mult timing: rs=0xFFFFFFFE (-2), rt=3, md_op=1 in cycle 0 → start=1 in cycle 0; busy=1 in cycles 1-5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu: rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div signed: rs=-7 (0xFFFFFFF9), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same operands via divu → lo=0x7FFFFFFC, hi=1.
- Div by zero and mthi/mflo:
  - Preload hi=0x11, lo=0x22 via mthi/mtlo.
  - Run div rt=0 → busy for 10 cycles; hi=0x11, lo=0x22 afterwards.
  - mflo → md_out=0x22.
- Launch while busy: mult with busy=1 → start=0 and the pending result is unchanged. With MDU_MADD_EN: hi=0, lo=5, then madd rs=2, rt=3 → lo=11, hi=0.

Source files
------------

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mdu_unit_if;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output md_op, rs_val, rt_val,
        input  start, busy, hi, lo, md_out
    );

    modport slave (
        input  md_op, rs_val, rt_val,
        output start, busy, hi, lo, md_out
    );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO multiply/divide unit for the E stage with fixed multi-cycle latency.
// Define MDU_MADD_EN to enable md_op=9 (madd, signed multiply-accumulate into HI/LO).
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave md
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] MC       = 4'(MULT_CYCLES);
    localparam logic [3:0] DC       = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [63:0] res;
    logic        acc;
    logic        dz;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        is_mul;
    logic        is_div;
    logic        is_madd;
    logic        launch;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] launch_res;

    assign is_mul = md.md_op == OP_MULT || md.md_op == OP_MULTU;
    assign is_div = md.md_op == OP_DIV || md.md_op == OP_DIVU;
`ifdef MDU_MADD_EN
    assign is_madd = md.md_op == 4'd9;
`else
    assign is_madd = 1'b0;
`endif
    assign md.busy  = cnt != 4'd0;
    assign launch   = (is_mul || is_div || is_madd) && !md.busy;
    assign md.start = launch;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.md_out = md.md_op == OP_MFHI ? hi_q : md.md_op == OP_MFLO ? lo_q : 32'd0;

    // Signed divide works on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    always_comb begin
        sign_a = md.md_op == OP_DIV && md.rs_val[31];
        sign_b = md.md_op == OP_DIV && md.rt_val[31];
        a_mag  = sign_a ? 32'd0 - md.rs_val : md.rs_val;
        b_mag  = sign_b ? 32'd0 - md.rt_val : md.rt_val;
        b_safe = b_mag == 32'd0 ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_s    = (sign_a ^ sign_b) ? 32'd0 - q_mag : q_mag;
        r_s    = sign_a ? 32'd0 - r_mag : r_mag;
        prod_s = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
        prod_u = {32'd0, md.rs_val} * {32'd0, md.rt_val};
        launch_res = is_div ? {r_s, q_s} : md.md_op == OP_MULTU ? prod_u : prod_s;
    end

    // Result is latched at launch; madd adds it to HI/LO as they stand at completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= 4'd0;
            res  <= 64'd0;
            acc  <= 1'b0;
            dz   <= 1'b0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (launch) begin
                cnt <= is_div ? DC : MC;
                res <= launch_res;
                acc <= is_madd;
                dz  <= is_div && md.rt_val == 32'd0;
            end else if (md.busy) begin
                cnt <= cnt - 4'd1;
            end
            if (cnt == 4'd1 && !dz) {hi_q, lo_q} <= acc ? {hi_q, lo_q} + res : res;
            if (!md.busy && md.md_op == OP_MTHI) hi_q <= md.rs_val;
            if (!md.busy && md.md_op == OP_MTLO) lo_q <= md.rs_val;
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and random checks of mdu_unit against a plain-arithmetic HI/LO model.
module tb_mdu_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit_if mif ();
    mdu_unit dut (.clk(clk), .reset(reset), .md(mif.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        case (op)
            4'd1: {m_hi, m_lo} = longint'($signed(a)) * longint'($signed(b));
            4'd2: {m_hi, m_lo} = 64'(a) * 64'(b);
            4'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            4'd9: {m_hi, m_lo} = {m_hi, m_lo} + 64'(longint'($signed(a)) * longint'($signed(b)));
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        mif.md_op = op;
        mif.rs_val = a;
        mif.rt_val = b;
        #1;
        if (op == 4'd7 || op == 4'd8) begin
            chk("mt_start", {31'd0, mif.start}, 32'd0);
            tick();
            mif.md_op = 4'd0;
            model(op, a, b);
            chk("mt_hi", mif.hi, m_hi);
            chk("mt_lo", mif.lo, m_lo);
        end else begin
            chk("start", {31'd0, mif.start}, 32'd1);
            tick();
            mif.md_op = 4'd0;
            for (int i = 0; i < n; i++) begin
                chk("busy", {31'd0, mif.busy}, 32'd1);
                chk("hold_hi", mif.hi, m_hi);
                chk("hold_lo", mif.lo, m_lo);
                tick();
            end
            model(op, a, b);
            chk("done_busy", {31'd0, mif.busy}, 32'd0);
            chk("res_hi", mif.hi, m_hi);
            chk("res_lo", mif.lo, m_lo);
        end
    endtask

    initial begin
        logic [3:0] ops [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
        logic [31:0] ra;
        logic [31:0] rb;
        mif.md_op = 4'd0;
        mif.rs_val = 32'd0;
        mif.rt_val = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_hi", mif.hi, 32'd0);
        chk("rst_lo", mif.lo, 32'd0);
        chk("rst_start", {31'd0, mif.start}, 32'd0);

        do_op(4'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi_k", mif.hi, 32'hFFFFFFFF);
        chk("mult_lo_k", mif.lo, 32'hFFFFFFFA);
        do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_hi_k", mif.hi, 32'hFFFFFFFE);
        chk("multu_lo_k", mif.lo, 32'h00000001);
        do_op(4'd3, 32'hFFFFFFF9, 32'd2);
        chk("div_lo_k", mif.lo, 32'hFFFFFFFD);
        chk("div_hi_k", mif.hi, 32'hFFFFFFFF);
        do_op(4'd4, 32'hFFFFFFF9, 32'd2);
        chk("divu_lo_k", mif.lo, 32'h7FFFFFFC);
        chk("divu_hi_k", mif.hi, 32'd1);
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("ovf_lo_k", mif.lo, 32'h80000000);
        chk("ovf_hi_k", mif.hi, 32'd0);

        do_op(4'd7, 32'h11, 32'd0);
        do_op(4'd8, 32'h22, 32'd0);
        do_op(4'd3, 32'd1234, 32'd0);
        chk("dz_hi_k", mif.hi, 32'h11);
        chk("dz_lo_k", mif.lo, 32'h22);
        mif.md_op = 4'd6;
        #1;
        chk("mflo", mif.md_out, 32'h22);
        mif.md_op = 4'd5;
        #1;
        chk("mfhi", mif.md_out, 32'h11);
        mif.md_op = 4'd0;
        #1;
        chk("md_out_none", mif.md_out, 32'd0);

        // Second mult presented mid-flight must be dropped.
        mif.md_op = 4'd1;
        mif.rs_val = 32'd7;
        mif.rt_val = 32'd6;
        #1;
        chk("lwb_start0", {31'd0, mif.start}, 32'd1);
        tick();
        mif.md_op = 4'd0;
        tick();
        mif.md_op = 4'd1;
        mif.rs_val = 32'd100;
        mif.rt_val = 32'd100;
        #1;
        chk("lwb_start", {31'd0, mif.start}, 32'd0);
        chk("lwb_busy", {31'd0, mif.busy}, 32'd1);
        tick();
        mif.md_op = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("lwb_busy_n", {31'd0, mif.busy}, 32'd1);
            tick();
        end
        model(4'd1, 32'd7, 32'd6);
        chk("lwb_done", {31'd0, mif.busy}, 32'd0);
        chk("lwb_hi", mif.hi, m_hi);
        chk("lwb_lo", mif.lo, 32'd42);

        mif.md_op = 4'd9;
        mif.rs_val = 32'd2;
        mif.rt_val = 32'd3;
`ifdef MDU_MADD_EN
        do_op(4'd7, 32'd0, 32'd0);
        do_op(4'd8, 32'd5, 32'd0);
        do_op(4'd9, 32'd2, 32'd3);
        chk("madd_lo_k", mif.lo, 32'd11);
        chk("madd_hi_k", mif.hi, 32'd0);
        do_op(4'd9, 32'hFFFFFFFD, 32'd7);
`else
        #1;
        chk("madd_off_start", {31'd0, mif.start}, 32'd0);
        tick();
        mif.md_op = 4'd0;
        chk("madd_off_busy", {31'd0, mif.busy}, 32'd0);
        chk("madd_off_hi", mif.hi, m_hi);
        chk("madd_off_lo", mif.lo, m_lo);
`endif

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            do_op(ops[$urandom_range(0, 5)], ra, rb);
        end

        do_op(4'd7, 32'h5A5A5A5A, 32'd0);
        mif.md_op = 4'd3;
        mif.rs_val = 32'd100;
        mif.rt_val = 32'd7;
        tick();
        mif.md_op = 4'd0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        mif.md_op = 4'd5;
        #1;
        chk("rst2_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst2_hi", mif.hi, 32'd0);
        chk("rst2_lo", mif.lo, 32'd0);
        chk("rst2_mfhi", mif.md_out, 32'd0);
        mif.md_op = 4'd0;
        for (int i = 0; i < 12; i++) tick();
        chk("rst2_hi_late", mif.hi, 32'd0);
        chk("rst2_lo_late", mif.lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
